// File: rtl/wb_ram_bist_master.sv
// Wishbone classic initiator that writes seed+i to N RAM words, reads them back and
// reports pass/fail, mismatch count, first failing index and bus timeout.
//
// state    | meaning
// S_IDLE   | waiting for start_i
// S_WR_REQ | write request on the bus, waiting for ack
// S_WR_GAP | one idle bus cycle after a write (late second ack ignored)
// S_RD_REQ | read request on the bus, compare on ack
// S_RD_GAP | one idle bus cycle after a read
// S_FINISH | publish done/pass, then back to idle
module wb_ram_bist_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          ADDR_WIDTH = 8,
    parameter int          TIMEOUT    = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [31:0]           seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  timeout_o,
    output logic [ADDR_WIDTH:0]   err_count_o,
    output logic [ADDR_WIDTH-1:0] first_err_addr_o,
    output logic                  wbm_cyc_o,
    output logic                  wbm_stb_o,
    output logic                  wbm_we_o,
    output logic [3:0]            wbm_sel_o,
    output logic [31:0]           wbm_adr_o,
    output logic [31:0]           wbm_dat_o,
    input  logic [31:0]           wbm_dat_i,
    input  logic                  wbm_ack_i
);

    localparam int                    TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0]      TMR_INIT = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]      TMR_ONE  = 1;
    localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;
    localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_GAP,
        S_RD_REQ,
        S_RD_GAP,
        S_FINISH
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]     len_q, len_d;
    logic [31:0]             seed_q, seed_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [ADDR_WIDTH:0]     err_d;
    logic [ADDR_WIDTH-1:0]   first_d;
    logic                    timeout_d, pass_d, done_d, busy_d;
    logic                    cyc_d, stb_d, we_d;
    logic [3:0]              sel_d;
    logic [31:0]             adr_d, dat_d;
    logic [31:0]             exp_word;
    logic                    last_idx;
    logic                    req_d;

    assign exp_word = seed_q + {{(32-ADDR_WIDTH){1'b0}}, idx_q};
    assign last_idx = ({1'b0, idx_q} == (len_q - CNT_ONE));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        seed_d    = seed_q;
        tmr_d     = tmr_q;
        err_d     = err_count_o;
        first_d   = first_err_addr_o;
        timeout_d = timeout_o;
        pass_d    = pass_o;
        busy_d    = busy_o;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    len_d     = len_i;
                    seed_d    = seed_i;
                    err_d     = '0;
                    first_d   = '0;
                    timeout_d = 1'b0;
                    pass_d    = 1'b0;
                    busy_d    = 1'b1;
                    idx_d     = '0;
                    tmr_d     = TMR_INIT;
                    state_d   = (len_i == '0) ? S_FINISH : S_WR_REQ;
                end
            end
            S_WR_REQ: begin
                if (wbm_ack_i) begin
                    state_d = S_WR_GAP;
                end else if (tmr_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_WR_GAP: begin
                tmr_d = TMR_INIT;
                if (last_idx) begin
                    idx_d   = '0;
                    state_d = S_RD_REQ;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_WR_REQ;
                end
            end
            S_RD_REQ: begin
                if (wbm_ack_i) begin
                    if (wbm_dat_i != exp_word) begin
                        if (err_count_o == '0) first_d = idx_q;
                        if (err_count_o != '1) err_d = err_count_o + CNT_ONE;
                    end
                    state_d = S_RD_GAP;
                end else if (tmr_q == '0) begin
                    timeout_d = 1'b1;
                    state_d   = S_FINISH;
                end else begin
                    tmr_d = tmr_q - TMR_ONE;
                end
            end
            S_RD_GAP: begin
                tmr_d = TMR_INIT;
                if (last_idx) begin
                    state_d = S_FINISH;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = S_RD_REQ;
                end
            end
            S_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                pass_d  = (err_count_o == '0) && !timeout_o;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Bus outputs are registered, so they are derived from the state being entered.
        req_d = (state_d == S_WR_REQ) || (state_d == S_RD_REQ);
        cyc_d = req_d;
        stb_d = req_d;
        we_d  = (state_d == S_WR_REQ);
        sel_d = req_d ? 4'hF : 4'h0;
        adr_d = req_d ? (BASE_ADDR | {{(32-ADDR_WIDTH){1'b0}}, idx_d}) : 32'h0;
        dat_d = we_d ? (seed_d + {{(32-ADDR_WIDTH){1'b0}}, idx_d}) : 32'h0;
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q          <= S_IDLE;
            idx_q            <= '0;
            len_q            <= '0;
            seed_q           <= '0;
            tmr_q            <= '0;
            err_count_o      <= '0;
            first_err_addr_o <= '0;
            timeout_o        <= 1'b0;
            pass_o           <= 1'b0;
            done_o           <= 1'b0;
            busy_o           <= 1'b0;
            wbm_cyc_o        <= 1'b0;
            wbm_stb_o        <= 1'b0;
            wbm_we_o         <= 1'b0;
            wbm_sel_o        <= 4'h0;
            wbm_adr_o        <= 32'h0;
            wbm_dat_o        <= 32'h0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            len_q            <= len_d;
            seed_q           <= seed_d;
            tmr_q            <= tmr_d;
            err_count_o      <= err_d;
            first_err_addr_o <= first_d;
            timeout_o        <= timeout_d;
            pass_o           <= pass_d;
            done_o           <= done_d;
            busy_o           <= busy_d;
            wbm_cyc_o        <= cyc_d;
            wbm_stb_o        <= stb_d;
            wbm_we_o         <= we_d;
            wbm_sel_o        <= sel_d;
            wbm_adr_o        <= adr_d;
            wbm_dat_o        <= dat_d;
        end
    end

endmodule

// File: tb/tb_wb_ram_bist_master.sv
// Scoreboard bench for wb_ram_bist_master with a behavioural RAM wrapper that acks one
// cycle after stb and can corrupt read data or withhold ack entirely.
module tb_wb_ram_bist_master;

    localparam int          AW   = 8;
    localparam int          TMO  = 16;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [AW:0] len_i = '0;
    logic [31:0] seed_i = '0;
    logic        busy, done, pass, tmo;
    logic [AW:0] err_cnt;
    logic [AW-1:0] first_err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o;
    logic [31:0] rdat = '0;
    logic        ack = 1'b0;

    always #5 clk = ~clk;

    wb_ram_bist_master #(.BASE_ADDR(BASE), .ADDR_WIDTH(AW), .TIMEOUT(TMO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .len_i(len_i), .seed_i(seed_i),
        .busy_o(busy), .done_o(done), .pass_o(pass), .timeout_o(tmo),
        .err_count_o(err_cnt), .first_err_addr_o(first_err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_sel_o(sel),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_dat_i(rdat), .wbm_ack_i(ack)
    );

    // RAM wrapper model: ack follows stb by one cycle, so it acks twice per access.
    logic [31:0] mem   [256];
    logic [31:0] cmask [256];
    bit          noack = 1'b0;

    always @(posedge clk) begin
        ack <= !noack && cyc && stb;
        if (cyc && stb && we) mem[adr[7:0]] <= dat_o;
        rdat <= mem[adr[7:0]] ^ cmask[adr[7:0]];
    end

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: got event expected none", name);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [AW:0] err;
        logic [AW-1:0] first;
        int          done_cyc;
    } res_t;

    bus_t bus_q[$];
    res_t res_q[$];

    always @(negedge clk) begin
        bus_t b;
        res_t r;
        if (!rst) begin
            if (cyc && stb && ack) begin
                if (bus_q.size() == 0) flag("spurious_xfer");
                else begin
                    b = bus_q.pop_front();
                    chk("xfer_we", 64'(we), 64'(b.we));
                    chk("xfer_adr", 64'(adr), 64'(b.adr));
                    chk("xfer_sel", 64'(sel), 64'h0F);
                    if (b.we) chk("xfer_dat", 64'(dat_o), 64'(b.dat));
                end
            end
            if (done) begin
                if (res_q.size() == 0) flag("spurious_done");
                else begin
                    r = res_q.pop_front();
                    chk("done_cycle", 64'(cnt), 64'(r.done_cyc));
                    chk("pass", 64'(pass), 64'(r.pass));
                    chk("timeout", 64'(tmo), 64'(r.tmo));
                    chk("err_count", 64'(err_cnt), 64'(r.err));
                    chk("first_err", 64'(first_err), 64'(r.first));
                    chk("busy_at_done", 64'(busy), 64'h0);
                end
            end
        end
    end

    task automatic push_bus(input int len, input logic [31:0] seed);
        bus_t b;
        for (int i = 0; i < len; i++) begin
            b.we = 1'b1; b.adr = BASE + 32'(i); b.dat = seed + 32'(i);
            bus_q.push_back(b);
        end
        for (int i = 0; i < len; i++) begin
            b.we = 1'b0; b.adr = BASE + 32'(i); b.dat = 32'h0;
            bus_q.push_back(b);
        end
    endtask

    task automatic pulse_start(input int len, input logic [31:0] seed);
        @(posedge clk);
        #1;
        len_i  = (AW+1)'(len);
        seed_i = seed;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_test(input int len, input logic [31:0] seed, input bit restart);
        res_t r;
        int   errs = 0;
        int   first = 0;
        int   lat;
        int   budget;
        int   stb_cycles = 0;
        for (int i = 0; i < len; i++) begin
            if (cmask[i] != 32'h0) begin
                if (errs == 0) first = i;
                errs++;
            end
        end
        if (len == 0) lat = 2;
        else if (noack) lat = TMO + 2;
        else lat = 6 * len + 2;
        r.pass  = (len == 0) || (!noack && errs == 0);
        r.tmo   = noack && (len != 0);
        r.err   = (noack || len == 0) ? '0 : (AW+1)'(errs);
        r.first = (noack || len == 0) ? '0 : AW'(first);
        if (!noack) push_bus(len, seed);
        @(posedge clk);
        #1;
        r.done_cyc = cnt + lat;
        res_q.push_back(r);
        len_i  = (AW+1)'(len);
        seed_i = seed;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (restart) begin
            repeat (5) @(posedge clk);
            #1;
            len_i  = 9'd3;
            seed_i = ~seed;
            start  = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        budget = 6 * len + 60;
        while (res_q.size() != 0 && budget > 0) begin
            @(negedge clk);
            if (stb) stb_cycles++;
            budget--;
        end
        if (res_q.size() != 0) begin
            flag("done_wait_expired");
            res_q.delete();
            bus_q.delete();
        end
        if (noack && len != 0) chk("stb_high_cycles", 64'(stb_cycles), 64'(TMO));
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'h0);
        chk("bus_q_drained", 64'(bus_q.size()), 64'h0);
    endtask

    initial begin
        int len;
        int b;
        logic [31:0] seed;
        for (int i = 0; i < 256; i++) begin
            mem[i]   = 32'h0;
            cmask[i] = 32'h0;
        end

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_done", 64'(done), 64'h0);
        chk("rst_pass", 64'(pass), 64'h0);
        chk("rst_tmo", 64'(tmo), 64'h0);
        chk("rst_err", 64'(err_cnt), 64'h0);
        chk("rst_first", 64'(first_err), 64'h0);
        chk("rst_cyc_stb_we", 64'({cyc, stb, we}), 64'h0);
        chk("rst_sel", 64'(sel), 64'h0);
        chk("rst_adr", 64'(adr), 64'h0);
        chk("rst_dat", 64'(dat_o), 64'h0);
        rst = 1'b0;

        run_test(4, 32'hA5A5_0000, 1'b0);

        cmask[2] = 32'h1;
        run_test(4, 32'hA5A5_0000, 1'b0);
        cmask[2] = 32'h0;

        noack = 1'b1;
        run_test(4, 32'h1234_5678, 1'b0);
        noack = 1'b0;

        run_test(0, 32'hDEAD_BEEF, 1'b0);

        run_test(256, 32'hFFFF_FFFF, 1'b1);

        // Reset in the middle of the read phase of a full-size test.
        seed = $urandom;
        push_bus(256, seed);
        pulse_start(256, seed);
        b = 3000;
        while (!(cyc && !we) && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (b == 0) flag("read_phase_wait_expired");
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_cyc", 64'(cyc), 64'h0);
        chk("midrst_stb", 64'(stb), 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        chk("midrst_done", 64'(done), 64'h0);
        repeat (2) @(posedge clk);
        bus_q.delete();
        res_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_test(1, $urandom, 1'b0);

        for (int it = 0; it < 10; it++) begin
            len = $urandom_range(0, 24);
            seed = $urandom;
            for (int i = 0; i < len; i++)
                if ($urandom_range(0, 3) == 0) cmask[i] = $urandom | 32'h1;
            noack = ($urandom_range(0, 7) == 0);
            run_test(len, seed, 1'b0);
            noack = 1'b0;
            for (int i = 0; i < 256; i++) cmask[i] = 32'h0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
